// File: rtl/hwpe_stream_array_concat_sync_pkg.sv
// hwpe_stream_array_concat_sync_pkg: shared helpers for the lane-concatenation block
package hwpe_stream_array_concat_sync_pkg;
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream bundle with byte strobes
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_concat_lane_fifo.sv
// hwpe_stream_concat_lane_fifo: per-lane buffer with registered ready and shared pop
module hwpe_stream_concat_lane_fifo #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   i_valid,
    input  logic [DATA_SIZE-1:0]   i_data,
    input  logic [DATA_SIZE/8-1:0] i_strb,
    input  logic                   i_pop,
    output logic                   o_ready,
    output logic                   o_not_empty,
    output logic [DATA_SIZE-1:0]   o_data,
    output logic [DATA_SIZE/8-1:0] o_strb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_SIZE+DATA_SIZE/8-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic w_push, w_pop;
    // depth is a power of two, so the count MSB alone marks a full lane
    assign o_ready     = rst_ni & ~clear_i & ~r_cnt[AW];
    assign o_not_empty = |r_cnt;
    assign w_push      = i_valid & o_ready;
    assign w_pop       = i_pop & o_not_empty;
    assign {o_strb, o_data} = r_mem[r_rptr];
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= r_wptr + AW'(w_push);
            r_rptr <= r_rptr + AW'(w_pop);
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= {i_strb, i_data};
    end
endmodule

// File: rtl/hwpe_stream_array_concat_sync.sv
// hwpe_stream_array_concat_sync: joins N buffered input lanes into one wide output stream
module hwpe_stream_array_concat_sync
    import hwpe_stream_array_concat_sync_pkg::*;
#(
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    hwpe_stream_intf_stream.sink     stream_i [NB_IN_STREAMS-1:0],
    hwpe_stream_intf_stream.source   stream_o,
    output logic [NB_IN_STREAMS-1:0] lane_empty_o
);
    localparam int unsigned SW = DATA_SIZE / 8;
    if (NB_IN_STREAMS < 2) begin : g_bad_nb
        $error("NB_IN_STREAMS must be at least 2");
    end
    if (DATA_SIZE == 0 || DATA_SIZE % 8 != 0) begin : g_bad_ds
        $error("DATA_SIZE must be a non-zero multiple of 8");
    end
    if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_fd
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    logic [NB_IN_STREAMS-1:0] w_not_empty;
    logic [DATA_SIZE-1:0]     w_head_data [NB_IN_STREAMS];
    logic [SW-1:0]            w_head_strb [NB_IN_STREAMS];
    logic [NB_IN_STREAMS*DATA_SIZE-1:0] w_data;
    logic [NB_IN_STREAMS*SW-1:0]        w_strb;
    logic w_pop;
    for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : g_lane
        hwpe_stream_concat_lane_fifo #(
            .DATA_SIZE (DATA_SIZE),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .i_valid    (stream_i[i].valid),
            .i_data     (stream_i[i].data),
            .i_strb     (stream_i[i].strb),
            .i_pop      (w_pop),
            .o_ready    (stream_i[i].ready),
            .o_not_empty(w_not_empty[i]),
            .o_data     (w_head_data[i]),
            .o_strb     (w_head_strb[i])
        );
    end
    always_comb begin
        w_data = '0;
        w_strb = '0;
        for (int k = 0; k < NB_IN_STREAMS; k++) begin
            w_data[k*DATA_SIZE +: DATA_SIZE] = w_head_data[k];
            w_strb[k*SW +: SW]               = w_head_strb[k];
        end
    end
    // a beat leaves only when every lane has one, so all lanes pop together
    assign stream_o.valid = rst_ni & ~clear_i & (&w_not_empty);
    assign stream_o.data  = w_data;
    assign stream_o.strb  = w_strb;
    assign w_pop          = stream_o.valid & stream_o.ready;
    assign lane_empty_o   = ~w_not_empty | {NB_IN_STREAMS{~rst_ni}};
endmodule

// File: doc/hwpe_stream_array_concat_sync.md
HWPE_STREAM_ARRAY_CONCAT_SYNC -- requirements
Module: hwpe_stream_array_concat_sync

Interface
REQ-001 SHALL have parameter NB_IN_STREAMS, default 2, number of input lanes concatenated into one output stream (>=2).
REQ-002 SHALL have parameter DATA_SIZE, default 32, per-lane data width in bits (multiple of 8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, per-lane buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous flush of all lane buffers.
REQ-007 SHALL have port stream_i  sink hwpe_stream_intf_stream array [NB_IN_STREAMS-1:0]  DATA_SIZE data, DATA_SIZE/8 strb  input lanes.
REQ-008 SHALL have port stream_o  source hwpe_stream_intf_stream  NB_IN_STREAMS*DATA_SIZE data, NB_IN_STREAMS*DATA_SIZE/8 strb  concatenated output.
REQ-009 SHALL have port lane_empty_o  output  NB_IN_STREAMS  bit i high when lane i buffer holds no entry.

Function
REQ-010 SHALL give each lane an independent FIFO: storage FIFO_DEPTH x (DATA_SIZE + DATA_SIZE/8), write pointer, read pointer ($clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH), count ($clog2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH).
REQ-011 SHALL drive stream_i[i].ready = rst_ni & ~clear_i & (count_i < FIFO_DEPTH); depends only on registered state, never on stream_o.ready.
REQ-012 SHALL push data/strb into lane i when stream_i[i].valid & stream_i[i].ready; write pointer +1, count +1.
REQ-013 SHALL drive stream_o.valid = ~clear_i & all lanes count > 0; no fall-through: beat accepted at edge t is visible on stream_o no earlier than cycle t+1.
REQ-014 SHALL drive stream_o.data[(i+1)*DATA_SIZE-1 : i*DATA_SIZE] and strb slice i from lane i head entry (lane 0 in LSBs).
REQ-015 SHALL pop all lanes simultaneously on stream_o.valid & stream_o.ready; read pointers +1, counts -1; no lane pops alone.
REQ-016 SHALL, on simultaneous push and pop in one lane, leave count unchanged and advance both pointers.
REQ-017 SHALL keep a full lane not-ready even if a pop occurs in the same cycle (ready from registered count only).
REQ-018 SHALL hold stream_o.valid and data stable until handshake once asserted (pop only on handshake; clear_i excepted).
REQ-019 SHALL, with clear_i high at a rising edge, zero all pointers and counts, discard contents, ignore pushes/pops that cycle.
REQ-020 SHALL tolerate lanes arriving skewed by up to FIFO_DEPTH beats with no data loss or lane misalignment.
REQ-021 SHALL drive lane_empty_o[i] = (count_i == 0).

Reset
REQ-022 SHALL, with rst_ni low at a rising edge, zero all pointers and counts; storage not reset.
REQ-023 SHALL hold stream_o.valid=0, all stream_i[i].ready=0, lane_empty_o all-ones while rst_ni is low; ready=1 first cycle after release.
REQ-024 SHALL behave on reset mid-transfer exactly as clear_i: all buffered beats discarded, no partial output beat.

Structure
REQ-025 SHALL add no new package typedefs; pointer/count widths derived locally with $clog2; parameter legality checked by elaboration-time assertions.
REQ-026 SHALL instantiate one sub-module per lane, hwpe_stream_concat_lane_fifo (storage, pointers, count, not-full/not-empty), with pop strobe shared from top.

Verification
REQ-027 SHALL cover aligned stream: NB=2, DATA_SIZE=32, lanes send 0xA0+k/0xB0+k same cycle, stream_o.ready=1 -> output {0xB0+k,0xA0+k} one cycle later, one beat per cycle, 8 beats.
REQ-028 SHALL cover skew: lane 0 sends 2 beats, lane 1 idle 5 cycles then sends 2 -> stream_o.valid=0 until cycle after lane 1 first push; lane 0 ready=0 after 2 pushes (FIFO_DEPTH=2).
REQ-029 SHALL cover backpressure: stream_o.ready=0 for 10 cycles with continuous input -> every lane fills to 2, all ready=0, stream_o data stable; releasing ready drains 2 beats in order.
REQ-030 SHALL cover full-lane simultaneous pop: lane full, stream_o handshake same cycle -> lane ready stays 0 that cycle, count drops to 1, ready=1 next cycle.
REQ-031 SHALL cover clear/reset mid-transfer: 1 beat buffered per lane, clear_i (then separately rst_ni=0) one cycle -> stream_o.valid=0, lane_empty_o=all-ones next cycle, no stale beat later emitted.
